// File: rtl/strip_xgpon_burst_header.sv
// Receive-side burst deframer: hunts the delimiter at any byte offset, locks it, and
// forwards re-aligned payload words as an AXIS frame closed by the trailer or a timeout.
module strip_xgpon_burst_header #(
  parameter logic [31:0] DELIMITER       = 32'hB2C50FA1,
  parameter logic [31:0] TRAILER         = 32'h82D6F416,
  parameter logic [15:0] MAX_BURST_WORDS = 16'd512
) (
  input  logic        axis_clk,
  input  logic        axis_resetn,
  input  logic [31:0] axis_TDATA_in,
  input  logic        axis_TVALID_in,
  output logic [31:0] axis_TDATA_out,
  output logic        axis_TVALID_out,
  output logic [3:0]  axis_TKEEP_out,
  output logic        axis_TLAST_out,
  output logic        axis_TUSER_out,
  input  logic        axis_TREADY_in,
  output logic        lock,
  output logic [1:0]  align_offset,
  output logic [15:0] burst_count,
  output logic        overflow
);

  typedef enum logic [0:0] {StHunt, StPayload} state_e;

  state_e      state_q;
  logic [31:0] prev_q;
  logic [1:0]  align_q;
  logic [15:0] word_cnt_q;
  logic [15:0] burst_cnt_q;
  logic [31:0] hold_q;
  logic        hold_full_q;
  logic [31:0] out_data_q;
  logic        out_valid_q;
  logic        out_last_q;
  logic        out_user_q;
  logic        overflow_q;

  logic [31:0] cand [4];
  logic        hunt_hit;
  logic [1:0]  hunt_k;
  logic [31:0] aligned;
  logic        is_trailer;
  logic        timeout;
  logic        push;
  logic [31:0] push_data;
  logic        push_last;
  logic        push_user;
  logic        accept;

  always_comb begin
    cand[0] = prev_q;
    cand[1] = {prev_q[23:0], axis_TDATA_in[31:24]};
    cand[2] = {prev_q[15:0], axis_TDATA_in[31:16]};
    cand[3] = {prev_q[7:0],  axis_TDATA_in[31:8]};
    hunt_hit = 1'b0;
    hunt_k   = 2'd0;
    // Descending scan so the lowest matching offset wins.
    for (int k = 3; k >= 0; k--) begin
      if (cand[k] == DELIMITER) begin
        hunt_hit = 1'b1;
        hunt_k   = 2'(k);
      end
    end
    aligned    = cand[align_q];
    is_trailer = (aligned == TRAILER);
    timeout    = (word_cnt_q == MAX_BURST_WORDS);
  end

  always_comb begin
    push      = 1'b0;
    push_data = hold_q;
    push_last = 1'b0;
    push_user = 1'b0;
    if (axis_TVALID_in && state_q == StPayload) begin
      if (is_trailer) begin
        push      = hold_full_q;
        push_last = 1'b1;
      end else if (timeout) begin
        push      = 1'b1;
        push_last = 1'b1;
        push_user = 1'b1;
        if (!hold_full_q) push_data = aligned;
      end else begin
        push = hold_full_q;
      end
    end
    accept = !out_valid_q || axis_TREADY_in;
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_resetn) begin
      state_q     <= StHunt;
      prev_q      <= '0;
      align_q     <= '0;
      word_cnt_q  <= '0;
      burst_cnt_q <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_user_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      // A rejected push loses the word and its TLAST; the held beat stays untouched.
      if (push) begin
        if (accept) begin
          out_valid_q <= 1'b1;
          out_data_q  <= push_data;
          out_last_q  <= push_last;
          out_user_q  <= push_user;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (axis_TREADY_in) begin
        out_valid_q <= 1'b0;
      end

      if (axis_TVALID_in) begin
        prev_q <= axis_TDATA_in;
        unique case (state_q)
          StHunt: begin
            if (hunt_hit) begin
              align_q    <= hunt_k;
              word_cnt_q <= '0;
              state_q    <= StPayload;
            end
          end
          StPayload: begin
            if (is_trailer) begin
              hold_full_q <= 1'b0;
              burst_cnt_q <= burst_cnt_q + 16'd1;
              state_q     <= StHunt;
            end else if (timeout) begin
              hold_full_q <= 1'b0;
              state_q     <= StHunt;
            end else begin
              hold_q      <= aligned;
              hold_full_q <= 1'b1;
              word_cnt_q  <= word_cnt_q + 16'd1;
            end
          end
          default: state_q <= StHunt;
        endcase
      end
    end
  end

  assign axis_TDATA_out  = out_data_q;
  assign axis_TVALID_out = out_valid_q;
  assign axis_TKEEP_out  = {4{out_valid_q}};
  assign axis_TLAST_out  = out_last_q;
  assign axis_TUSER_out  = out_user_q;
  assign lock            = (state_q == StPayload);
  assign align_offset    = align_q;
  assign burst_count     = burst_cnt_q;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_strip_xgpon_burst_header.sv
// Bench for strip_xgpon_burst_header: byte-level reference model checked every cycle,
// directed bursts with literal expectations, then randomized bursts with random backpressure.
module tb_strip_xgpon_burst_header;

  localparam logic [31:0] DELIM = 32'hB2C50FA1;
  localparam logic [31:0] TRAIL = 32'h82D6F416;
  localparam int          MAXW  = 4;

  logic        axis_clk = 1'b0;
  logic        axis_resetn;
  logic [31:0] axis_TDATA_in;
  logic        axis_TVALID_in;
  logic [31:0] axis_TDATA_out;
  logic        axis_TVALID_out;
  logic [3:0]  axis_TKEEP_out;
  logic        axis_TLAST_out;
  logic        axis_TUSER_out;
  logic        axis_TREADY_in;
  logic        lock;
  logic [1:0]  align_offset;
  logic [15:0] burst_count;
  logic        overflow;

  always #5 axis_clk = ~axis_clk;

  strip_xgpon_burst_header #(
    .DELIMITER      (DELIM),
    .TRAILER        (TRAIL),
    .MAX_BURST_WORDS(16'(MAXW))
  ) dut (
    .axis_clk       (axis_clk),
    .axis_resetn    (axis_resetn),
    .axis_TDATA_in  (axis_TDATA_in),
    .axis_TVALID_in (axis_TVALID_in),
    .axis_TDATA_out (axis_TDATA_out),
    .axis_TVALID_out(axis_TVALID_out),
    .axis_TKEEP_out (axis_TKEEP_out),
    .axis_TLAST_out (axis_TLAST_out),
    .axis_TUSER_out (axis_TUSER_out),
    .axis_TREADY_in (axis_TREADY_in),
    .lock           (lock),
    .align_offset   (align_offset),
    .burst_count    (burst_count),
    .overflow       (overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stream of bytes, burst = list of aligned words, emitted one word late.
  logic        s_valid, s_ready, s_rstn;
  logic [31:0] s_data;
  bit          m_lock;
  logic [1:0]  m_off;
  logic [31:0] m_prev;
  logic [31:0] m_pend;
  bit          m_have;
  int          m_nwords;
  logic [15:0] m_bursts;
  bit          m_ovf;
  bit          m_ov;
  logic [33:0] m_beat;

  logic [33:0] got [$];
  bit          last_ov = 1'b0;
  logic [33:0] last_beat;

  function automatic logic [31:0] pick(input logic [31:0] p, input logic [31:0] c, input int k);
    logic [7:0] b [8];
    for (int i = 0; i < 4; i++) begin
      b[i]     = p[31-8*i -: 8];
      b[4 + i] = c[31-8*i -: 8];
    end
    return {b[k], b[k+1], b[k+2], b[k+3]};
  endfunction

  task automatic model_step();
    bit          do_push;
    logic [33:0] pw;
    logic [31:0] a;
    bit          found;
    if (!s_rstn) begin
      m_lock = 0; m_off = '0; m_prev = '0; m_pend = '0; m_have = 0; m_nwords = 0;
      m_bursts = '0; m_ovf = 0; m_ov = 0; m_beat = '0;
      return;
    end
    do_push = 0;
    pw      = '0;
    if (s_valid) begin
      if (!m_lock) begin
        found = 0;
        for (int k = 0; k < 4; k++) begin
          if (!found && pick(m_prev, s_data, k) == DELIM) begin
            found = 1;
            m_off = 2'(k);
          end
        end
        if (found) begin
          m_lock = 1; m_nwords = 0; m_have = 0;
        end
      end else begin
        a = pick(m_prev, s_data, int'(m_off));
        if (a == TRAIL) begin
          if (m_have) begin do_push = 1; pw = {2'b01, m_pend}; end
          m_bursts = m_bursts + 16'd1;
          m_lock = 0; m_have = 0;
        end else if (m_nwords == MAXW) begin
          do_push = 1;
          pw = {2'b11, (m_have ? m_pend : a)};
          m_lock = 0; m_have = 0;
        end else begin
          if (m_have) begin do_push = 1; pw = {2'b00, m_pend}; end
          m_pend = a; m_have = 1; m_nwords++;
        end
      end
      m_prev = s_data;
    end
    if (do_push) begin
      if (!m_ov || s_ready) begin m_ov = 1; m_beat = pw; end
      else m_ovf = 1;
    end else if (m_ov && s_ready) begin
      m_ov = 0;
    end
  endtask

  initial begin : compare
    forever begin
      @(posedge axis_clk);
      s_valid = axis_TVALID_in;
      s_data  = axis_TDATA_in;
      s_ready = axis_TREADY_in;
      s_rstn  = axis_resetn;
      if (last_ov && s_ready) got.push_back(last_beat);
      model_step();
      @(negedge axis_clk);
      chk("tvalid", axis_TVALID_out, m_ov);
      chk("tkeep", axis_TKEEP_out, m_ov ? 4'hF : 4'h0);
      chk("lock", lock, m_lock);
      chk("align_offset", align_offset, m_off);
      chk("burst_count", burst_count, m_bursts);
      chk("overflow", overflow, m_ovf);
      if (m_ov) chk("beat {tuser,tlast,tdata}", {axis_TUSER_out, axis_TLAST_out, axis_TDATA_out},
                    m_beat);
      last_ov   = axis_TVALID_out;
      last_beat = {axis_TUSER_out, axis_TLAST_out, axis_TDATA_out};
    end
  end

  // 0: ready high, 1: ready low, 2: random ready
  int ready_mode = 0;

  task automatic drive_ready();
    if (ready_mode == 0) axis_TREADY_in = 1'b1;
    else if (ready_mode == 1) axis_TREADY_in = 1'b0;
    else axis_TREADY_in = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [31:0] w);
    @(negedge axis_clk);
    axis_TVALID_in = 1'b1;
    axis_TDATA_in  = w;
    drive_ready();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge axis_clk);
      axis_TVALID_in = 1'b0;
      axis_TDATA_in  = 32'($urandom);
      drive_ready();
    end
  endtask

  task automatic pulse_reset();
    @(negedge axis_clk);
    axis_resetn    = 1'b0;
    axis_TVALID_in = 1'b0;
    @(negedge axis_clk);
    axis_resetn = 1'b1;
  endtask

  task automatic chk_beats(input string name, input int n, input logic [33:0] e0,
                           input logic [33:0] e1, input logic [33:0] e2, input logic [33:0] e3);
    logic [33:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk({name, " beat count"}, got.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got.size()) chk({name, " beat"}, got[i], e[i]);
    end
  endtask

  logic [7:0] bq [$];

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) bq.push_back(w[31-8*i -: 8]);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] w;
    axis_resetn    = 1'b0;
    axis_TVALID_in = 1'b0;
    axis_TDATA_in  = '0;
    axis_TREADY_in = 1'b1;
    repeat (3) @(negedge axis_clk);
    chk("reset tvalid", axis_TVALID_out, 1'b0);
    chk("reset tdata", axis_TDATA_out, 32'h0);
    chk("reset lock", lock, 1'b0);
    chk("reset burst_count", burst_count, 16'h0);
    chk("reset overflow", overflow, 1'b0);
    axis_resetn = 1'b1;

    // Aligned burst, offset 0; filler word lets the trailer reach the aligned position.
    got.delete();
    for (int i = 0; i < 3; i++) send(32'h05560556);
    send(DELIM); send(32'h11111111); send(32'h22222222); send(TRAIL); send(32'h0);
    idle(3);
    chk_beats("offset0", 2, {2'b00, 32'h11111111}, {2'b01, 32'h22222222}, '0, '0);
    chk("offset0 burst_count", burst_count, 16'd1);
    chk("offset0 align", align_offset, 2'd0);
    chk("offset0 lock", lock, 1'b0);

    // Offset 2
    got.delete();
    send(32'h0556B2C5); send(32'h0FA1AAAA); send(32'hBBBBCCCC);
    send(32'hCCCC82D6); send(32'hF4160000);
    idle(3);
    chk("offset2 align", align_offset, 2'd2);
    chk_beats("offset2", 2, {2'b00, 32'hAAAABBBB}, {2'b01, 32'hCCCCCCCC}, '0, '0);
    chk("offset2 burst_count", burst_count, 16'd2);

    // Zero-length burst
    got.delete();
    send(DELIM); send(TRAIL); send(32'h0);
    idle(3);
    chk_beats("zero-length", 0, '0, '0, '0, '0);
    chk("zero-length burst_count", burst_count, 16'd3);
    chk("zero-length lock", lock, 1'b0);

    // Timeout after MAXW words
    got.delete();
    send(DELIM);
    for (int i = 1; i <= 6; i++) send(32'(i));
    send(32'h0);
    idle(3);
    chk_beats("timeout", 4, {2'b00, 32'h1}, {2'b00, 32'h2}, {2'b00, 32'h3}, {2'b11, 32'h4});
    chk("timeout burst_count", burst_count, 16'd3);
    chk("timeout lock", lock, 1'b0);

    // Backpressure: first beat held, later pushes dropped
    got.delete();
    ready_mode = 1;
    send(DELIM);
    for (int i = 1; i <= 4; i++) send(32'h0A0A0000 + 32'(i));
    send(TRAIL); send(32'h0);
    idle(2);
    chk("bp tvalid", axis_TVALID_out, 1'b1);
    chk("bp tdata", axis_TDATA_out, 32'h0A0A0001);
    chk("bp tlast", axis_TLAST_out, 1'b0);
    chk("bp overflow", overflow, 1'b1);
    chk("bp burst_count", burst_count, 16'd4);
    ready_mode = 0;
    idle(3);
    chk_beats("bp drain", 1, {2'b00, 32'h0A0A0001}, '0, '0, '0);
    chk("bp overflow sticky", overflow, 1'b1);
    pulse_reset();
    chk("bp overflow after reset", overflow, 1'b0);
    chk("bp burst_count after reset", burst_count, 16'd0);

    // Reset mid-burst
    got.delete();
    send(DELIM); send(32'h0C0C0001); send(32'h0C0C0002); send(32'h0C0C0003);
    pulse_reset();
    chk("midreset tvalid", axis_TVALID_out, 1'b0);
    chk("midreset lock", lock, 1'b0);
    chk("midreset tdata", axis_TDATA_out, 32'h0);
    chk("midreset align", align_offset, 2'd0);
    got.delete();
    for (int i = 4; i <= 7; i++) send(32'h0C0C0000 + 32'(i));
    idle(3);
    chk_beats("midreset after", 0, '0, '0, '0, '0);
    chk("midreset after lock", lock, 1'b0);

    // Randomized bursts at random offsets, gaps and backpressure
    ready_mode = 2;
    for (int b = 0; b < 60; b++) begin
      bq.delete();
      repeat ($urandom_range(0, 7)) bq.push_back(8'($urandom));
      push_word(DELIM);
      repeat ($urandom_range(0, 6)) push_word($urandom);
      if ($urandom_range(0, 4) != 0) push_word(TRAIL);
      repeat ($urandom_range(0, 7)) bq.push_back(8'($urandom));
      while (bq.size() % 4 != 0) bq.push_back(8'($urandom));
      while (bq.size() != 0) begin
        w = {bq[0], bq[1], bq[2], bq[3]};
        repeat (4) void'(bq.pop_front());
        while ($urandom_range(0, 3) == 0) idle(1);
        send(w);
      end
    end
    ready_mode = 0;
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
